// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and baud divisor helper.
// Also intended for the future RX block.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam int unsigned DATA_BITS = 8;

    function automatic int unsigned calc_baud_div(input int unsigned freq,
                                                  input int unsigned baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO with count-based full/empty.
// A write and a pop in the same cycle are both honoured, even when full.
module sync_byte_fifo #(
    parameter int DEPTH     = 8,
    parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en_i,
    input  logic [7:0]           wr_data_i,
    input  logic                 rd_en_i,
    output logic [7:0]           rd_data_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [CNT_WIDTH-1:0] count_o,
    output logic                 wr_drop_o
);

    localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]           mem_q [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr_q;
    logic [PTR_WIDTH-1:0] rd_ptr_q;
    logic [CNT_WIDTH-1:0] count_q;
    logic                 do_wr;
    logic                 do_rd;

    assign full_o    = (count_q == CNT_WIDTH'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign do_rd     = rd_en_i & ~empty_o;
    // A pop frees the head slot this cycle, so a write is still accepted when full.
    assign do_wr     = wr_en_i & (~full_o | do_rd);
    assign wr_drop_o = wr_en_i & ~do_wr;
    assign rd_data_o = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + PTR_WIDTH'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + PTR_WIDTH'(1);
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + CNT_WIDTH'(1);
                2'b01:   count_q <= count_q - CNT_WIDTH'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; count_q gates every read, so stale
    // entries are never observable and the array can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/uart_tx_byte_fifo.sv
// Strobe-fed byte FIFO feeding a UART transmitter (start, 8 data LSB first, stop).
// Define UART_TX_PARITY_EN to insert an even parity bit after data bit 7.
module uart_tx_byte_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CLK_FREQ   = 125000000,
    parameter int BAUD_RATE  = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic       wr_strobe,
    output logic       tx,
    output logic       ready,
    output logic       full,
    output logic       empty,
    output logic       tx_busy,
    output logic       overflow
);

    localparam int unsigned BAUD_DIV  = calc_baud_div(CLK_FREQ, BAUD_RATE);
    localparam int          CNT_WIDTH = $clog2(FIFO_DEPTH + 1);
    localparam int          BAUD_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);

    tx_state_e            state_q, state_d;
    logic [BAUD_W-1:0]    baud_cnt_q, baud_cnt_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [7:0]           shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 wr_strobe_q;
    logic                 overflow_q;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    logic                 wr;
    logic                 pop;
    logic                 bit_last;
    logic [7:0]           fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_drop;
    logic [CNT_WIDTH-1:0] fifo_count;

    assign wr       = wr_strobe & ~wr_strobe_q;
    assign bit_last = (baud_cnt_q == BAUD_LAST);

    sync_byte_fifo #(
        .DEPTH     (FIFO_DEPTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wr),
        .wr_data_i (data_in),
        .rd_en_i   (pop),
        .rd_data_o (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count),
        .wr_drop_o (fifo_drop)
    );

    // NOTE: every variable driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = (state_q == IDLE || bit_last) ? '0 : baud_cnt_q + BAUD_W'(1);
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_head;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^fifo_head;
`endif
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_last) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            DATA: begin
                if (bit_last) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_last) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_last) begin
                    // Chain straight into the next start bit so frames have no idle gap.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_head;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^fifo_head;
`endif
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_strobe_q <= 1'b0;
            state_q     <= IDLE;
            baud_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            tx_q        <= 1'b1;
            overflow_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            wr_strobe_q <= wr_strobe;
            state_q     <= state_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            overflow_q  <= fifo_drop;
`ifdef UART_TX_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign tx       = tx_q;
    assign tx_busy  = (state_q != IDLE);
    assign overflow = overflow_q;
    assign full     = fifo_full;
    assign empty    = fifo_empty;
    assign ready    = (fifo_count < CNT_WIDTH'(FIFO_DEPTH));

endmodule

// File: tb/tb_uart_tx_byte_fifo.sv
// Self-checking bench: directed scenarios plus random strobe traffic, all compared
// each cycle against a queue-based model of the byte buffer and line timing.
module tb_uart_tx_byte_fifo;

    localparam int CLK_FREQ   = 1000000;
    localparam int BAUD_RATE  = 100000;
    localparam int FIFO_DEPTH = 8;
    localparam int BAUD_DIV   = CLK_FREQ / BAUD_RATE;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME = FRAME_BITS * BAUD_DIV;

    logic       clk;
    logic       rst_n;
    logic [7:0] data_in;
    logic       wr_strobe;
    logic       tx;
    logic       ready;
    logic       full;
    logic       empty;
    logic       tx_busy;
    logic       overflow;

    uart_tx_byte_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD_RATE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .wr_strobe (wr_strobe),
        .tx        (tx),
        .ready     (ready),
        .full      (full),
        .empty     (empty),
        .tx_busy   (tx_busy),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc_e    = 0;

    // Reference model: pending bytes, the byte on the line and when its frame began.
    logic [7:0] m_q[$];
    logic       m_prev_stb;
    logic       m_have;
    int         m_start;
    int         m_next_pop;
    logic [7:0] m_cur;
    logic       m_ovf;

    // Per-scenario observations of the DUT.
    int   tr_busy;
    int   tr_ovf;
    int   tr_rises;
    logic prev_busy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            if (n_errors <= 25)
                $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, got, exp, cyc_e);
        end
    endtask

    // Line level of bit slot k of a frame carrying byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        int ones;
        if (k == 0) return 1'b0;
        if (k <= 8) return ((int'(b) >> (k - 1)) % 2) == 1;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += (int'(b) >> i) % 2;
        if (FRAME_BITS == 11 && k == 9) return (ones % 2) == 1;
        return 1'b1;
    endfunction

    function automatic logic m_busy();
        return m_have && (cyc_e < m_start + FRAME);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_prev_stb = 1'b0;
        m_have     = 1'b0;
        m_start    = 0;
        m_next_pop = 0;
        m_cur      = 8'h00;
        m_ovf      = 1'b0;
    endtask

    // One clock edge: the line takes the head byte when it is free, then the write lands.
    task automatic model_edge(input logic stb, input logic [7:0] d);
        logic wr_req;
        wr_req     = stb && !m_prev_stb;
        m_prev_stb = stb;
        m_ovf      = 1'b0;
        if (m_q.size() > 0 && cyc_e >= m_next_pop) begin
            m_cur      = m_q.pop_front();
            m_have     = 1'b1;
            m_start    = cyc_e;
            m_next_pop = cyc_e + FRAME;
        end
        if (wr_req) begin
            if (m_q.size() < FIFO_DEPTH) m_q.push_back(d);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic compare_outputs();
        logic busy;
        logic exp_tx;
        busy   = m_busy();
        exp_tx = busy ? frame_bit(m_cur, (cyc_e - m_start) / BAUD_DIV) : 1'b1;
        check("tx", tx, exp_tx);
        check("tx_busy", tx_busy, busy);
        check("empty", empty, m_q.size() == 0);
        check("full", full, m_q.size() == FIFO_DEPTH);
        check("ready", ready, m_q.size() < FIFO_DEPTH);
        check("overflow", overflow, m_ovf);
        tr_busy += int'(tx_busy);
        tr_ovf  += int'(overflow);
        if (tx_busy && !prev_busy) tr_rises++;
        prev_busy = tx_busy;
    endtask

    // Drive inputs at the falling edge, advance one rising edge, compare at the next falling edge.
    task automatic tick(input logic stb, input logic [7:0] d);
        wr_strobe = stb;
        data_in   = d;
        @(posedge clk);
        cyc_e++;
        if (!rst_n) model_reset();
        else model_edge(stb, d);
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic clear_obs();
        tr_busy  = 0;
        tr_ovf   = 0;
        tr_rises = 0;
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while ((m_q.size() > 0 || m_busy()) && n < max_cycles) begin
            tick(1'b0, 8'($urandom));
            n++;
        end
        if (n >= max_cycles) check("drain_budget", 32'(n), 32'(max_cycles - 1));
        tick(1'b0, 8'h00);
    endtask

    // Asynchronous reset taken between clock edges, checked before the next edge.
    task automatic pulse_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, "_tx"}, tx, 1'b1);
        check({tag, "_empty"}, empty, 1'b1);
        check({tag, "_busy"}, tx_busy, 1'b0);
        check({tag, "_full"}, full, 1'b0);
        model_reset();
        tick(1'b0, 8'h00);
        tick(1'b0, 8'h00);
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        wr_strobe = 1'b0;
        data_in   = 8'h00;
        prev_busy = 1'b0;
        model_reset();
        clear_obs();

        // Reset state
        @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_ready", ready, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        tick(1'b0, 8'h00);
        rst_n = 1'b1;
        repeat (3) tick(1'b0, 8'h00);

        // Single byte 0xA5: start on the edge after the write, one clean frame
        clear_obs();
        tick(1'b1, 8'hA5);
        check("a5_tx_before_start", tx, 1'b1);
        check("a5_empty_after_write", empty, 1'b0);
        tick(1'b0, 8'h00);
        check("a5_start_bit", tx, 1'b0);
        drain(2 * FRAME);
        check("a5_busy_cycles", 32'(tr_busy), 32'(FRAME));

        // Burst of 10 writes: the first goes straight to the line, the 10th is dropped
        clear_obs();
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 8'(i));
            if (i == 8) begin
                check("burst_full_after_9", full, 1'b1);
                check("burst_ready_after_9", ready, 1'b0);
            end
            tick(1'b0, 8'hEE);
        end
        check("burst_overflow_pulses", 32'(tr_ovf), 32'd1);
        drain(12 * FRAME);
        check("burst_busy_cycles", 32'(tr_busy), 32'(9 * FRAME));

        // Back-to-back frames with no idle gap
        clear_obs();
        tick(1'b1, 8'h55);
        tick(1'b0, 8'h00);
        tick(1'b1, 8'hFF);
        tick(1'b0, 8'h00);
        drain(4 * FRAME);
        check("b2b_busy_cycles", 32'(tr_busy), 32'(2 * FRAME));
        check("b2b_busy_rises", 32'(tr_rises), 32'd1);

        // Reset during data bit 3 with bytes queued, then a clean frame afterwards
        tick(1'b1, 8'h3C);
        tick(1'b0, 8'h00);
        tick(1'b1, 8'h11);
        tick(1'b0, 8'h00);
        tick(1'b1, 8'h22);
        tick(1'b0, 8'h00);
        for (int n = 0; n < FRAME && cyc_e < m_start + 4 * BAUD_DIV + 5; n++) tick(1'b0, 8'h00);
        pulse_reset("midframe_rst");
        clear_obs();
        tick(1'b1, 8'h81);
        tick(1'b0, 8'h00);
        drain(2 * FRAME);
        check("post_rst_busy_cycles", 32'(tr_busy), 32'(FRAME));

        // Strobe held high for 5 cycles: one byte, one frame
        clear_obs();
        repeat (5) tick(1'b1, 8'h7E);
        tick(1'b0, 8'h00);
        drain(2 * FRAME);
        check("held_busy_cycles", 32'(tr_busy), 32'(FRAME));
        check("held_busy_rises", 32'(tr_rises), 32'd1);

        // Random strobe traffic; data changes while the strobe stays high
        for (int b = 0; b < 80; b++) begin
            int hi;
            int lo;
            logic [7:0] d;
            hi = $urandom_range(1, 4);
            lo = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3 * FRAME) : $urandom_range(1, 3);
            d  = 8'($urandom);
            for (int j = 0; j < hi; j++) tick(1'b1, (j == 0) ? d : 8'($urandom));
            for (int j = 0; j < lo; j++) tick(1'b0, 8'($urandom));
            if (b == 40) pulse_reset("rand_rst");
        end
        drain(12 * FRAME);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
